// File: rtl/mix_pkg.sv
// Shared MIX datapath definitions: default word width, divider FSM states and
// a sign-magnitude word type.
package mix_pkg;

    localparam int WORD_W = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic              sign;
        logic [WORD_W-1:0] mag;
    } mix_word_t;

endpackage

// File: rtl/mix_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if it fits.
module mix_div_step #(
    parameter int W = 30
) (
    input  logic [W:0]   rem_in,
    input  logic         din,
    input  logic [W-1:0] div,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;

    // rem_in is always below the divisor, so its top bit is zero and the
    // shift cannot lose information.
    assign shifted = {rem_in[W-1:0], din};

    always_comb begin
        if (shifted >= {1'b0, div}) begin
            rem_out = shifted - {1'b0, div};
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted;
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/mix_div_seq.sv
// Multi-cycle sign-magnitude divider (rA:rX / V) with start/busy/done handshake.
// Remainder output is built only when MIX_DIV_REMAINDER_EN is defined.
module mix_div_seq
    import mix_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a_hi,
    input  logic [W-1:0] a_lo,
    input  logic         a_sign,
    input  logic [W-1:0] v,
    input  logic         v_sign,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [W-1:0] q,
    output logic         q_sign,
    output logic [W-1:0] r,
    output logic         r_sign
);

    localparam int CW = $clog2(W + 1);

    div_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]   rem_q, rem_d;
    logic [W-1:0] shf_q, shf_d;
    logic [W-1:0] v_q, v_d;
    logic         a_sign_q, a_sign_d;
    logic         v_sign_q, v_sign_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] q_q, q_d;
    logic         q_sign_q, q_sign_d;
`ifdef MIX_DIV_REMAINDER_EN
    logic [W-1:0] r_q, r_d;
    logic         r_sign_q, r_sign_d;
`endif

    logic [W:0] step_rem;
    logic       step_q;

    mix_div_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .din     (shf_q[W-1]),
        .div     (v_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        shf_d    = shf_q;
        v_d      = v_q;
        a_sign_d = a_sign_q;
        v_sign_d = v_sign_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        q_d      = q_q;
        q_sign_d = q_sign_q;
`ifdef MIX_DIV_REMAINDER_EN
        r_d      = r_q;
        r_sign_d = r_sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sign_d = a_sign;
                    v_sign_d = v_sign;
                    v_d      = v;
                    ovf_d    = 1'b0;
                    // Quotient would not fit in W bits (covers v == 0 too).
                    if (a_hi >= v) begin
                        ovf_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = {1'b0, a_hi};
                        shf_d   = a_lo;
                        cnt_d   = CW'(W);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Dividend bits leave the top of shf while quotient bits enter the bottom.
                rem_d = step_rem;
                shf_d = {shf_q[W-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    q_d      = {shf_q[W-2:0], step_q};
                    q_sign_d = a_sign_q ^ v_sign_q;
`ifdef MIX_DIV_REMAINDER_EN
                    r_d      = step_rem[W-1:0];
                    r_sign_d = a_sign_q;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            shf_q    <= '0;
            v_q      <= '0;
            a_sign_q <= 1'b0;
            v_sign_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            q_q      <= '0;
            q_sign_q <= 1'b0;
`ifdef MIX_DIV_REMAINDER_EN
            r_q      <= '0;
            r_sign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            shf_q    <= shf_d;
            v_q      <= v_d;
            a_sign_q <= a_sign_d;
            v_sign_q <= v_sign_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            q_q      <= q_d;
            q_sign_q <= q_sign_d;
`ifdef MIX_DIV_REMAINDER_EN
            r_q      <= r_d;
            r_sign_q <= r_sign_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign q      = q_q;
    assign q_sign = q_sign_q;
`ifdef MIX_DIV_REMAINDER_EN
    assign r      = r_q;
    assign r_sign = r_sign_q;
`else
    assign r      = '0;
    assign r_sign = 1'b0;
`endif

endmodule

// File: tb/tb_mix_div_seq.sv
// Self-checking bench for mix_div_seq: directed vectors plus randomized
// divisions checked against an arithmetic reference model.
module tb_mix_div_seq;

    localparam int W = 30;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_hi = '0;
    logic [W-1:0] a_lo = '0;
    logic         a_sign = 1'b0;
    logic [W-1:0] v = '0;
    logic         v_sign = 1'b0;
    logic         busy, done, ovf, q_sign, r_sign;
    logic [W-1:0] q, r;

    int total = 0;
    int bad   = 0;

    // Reference model state: results persist across overflow operations.
    logic [W-1:0] m_q = '0, m_r = '0;
    logic         m_qs = 1'b0, m_rs = 1'b0, m_ovf = 1'b0;
    int           m_lat = 0;

    mix_div_seq #(.W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_hi   (a_hi),
        .a_lo   (a_lo),
        .a_sign (a_sign),
        .v      (v),
        .v_sign (v_sign),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .q      (q),
        .q_sign (q_sign),
        .r      (r),
        .r_sign (r_sign)
    );

    always #5 clk = ~clk;

    // Arithmetic model of one DIV: overflow leaves results unchanged.
    task automatic model_div(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic as_,
                             input logic [W-1:0] vv, input logic vs);
        logic [2*W-1:0] dividend, quo, rem;
        if (hi >= vv) begin
            m_ovf = 1'b1;
            m_lat = 0;
        end else begin
            dividend = {hi, lo};
            quo      = dividend / {{W{1'b0}}, vv};
            rem      = dividend % {{W{1'b0}}, vv};
            m_ovf    = 1'b0;
            m_lat    = W;
            m_q      = quo[W-1:0];
            m_qs     = as_ ^ vs;
`ifdef MIX_DIV_REMAINDER_EN
            m_r      = rem[W-1:0];
            m_rs     = as_;
`else
            m_r      = '0;
            m_rs     = 1'b0;
`endif
        end
    endtask

    // Issue one operation; report done latency (edges after accept), busy-high
    // sample count and number of further done pulses within `tail` cycles.
    task automatic run_op(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic as_,
                          input logic [W-1:0] vv, input logic vs, input int p1, input int p2,
                          input int tail, output int lat, output int bcnt, output int extra);
        @(negedge clk);
        a_hi = hi; a_lo = lo; a_sign = as_; v = vv; v_sign = vs; start = 1'b1;
        lat = -1; bcnt = 0; extra = 0;
        @(posedge clk);
        for (int e = 0; e <= W + 4; e++) begin
            @(negedge clk);
            if (busy) bcnt++;
            start = (e + 1 == p1) || (e + 1 == p2);
            if (done) begin
                lat = e;
                break;
            end
            @(posedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < tail; c++) begin
            @(negedge clk);
            if (done) extra++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
        total++; if ({q, q_sign, r, r_sign} !== '0) begin
            bad++; $display("FAIL reset_results got q=%0d qs=%0b r=%0d rs=%0b want all 0", q, q_sign, r, r_sign);
        end
        reset = 1'b0;
        $display("reset: busy=%0b done=%0b ovf=%0b q=%0d r=%0d", busy, done, ovf, q, r);
    endtask

    task automatic test_spec_vectors;
        logic [W-1:0] t_hi[2] = '{30'd1954, 30'd0};
        logic [W-1:0] t_lo[2] = '{30'd479399779, 30'd100};
        logic [W-1:0] t_v[2]  = '{30'd837504, 30'd7};
        logic         t_as[2] = '{1'b0, 1'b1};
        logic [W-1:0] x_q[2]  = '{30'd2505744, 30'd14};
        logic [W-1:0] x_r[2]  = '{30'd300899, 30'd2};
        logic         x_qs[2] = '{1'b0, 1'b1};
        int lat, bcnt, extra;
        for (int i = 0; i < 2; i++) begin
            run_op(t_hi[i], t_lo[i], t_as[i], t_v[i], 1'b0, -1, -1, 0, lat, bcnt, extra);
            $display("vector %0d: lat=%0d q=%0d qs=%0b r=%0d rs=%0b ovf=%0b", i, lat, q, q_sign, r, r_sign, ovf);
            total++; if (lat !== W) begin bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, W); end
            total++; if (bcnt !== W) begin bad++; $display("FAIL vec%0d_busy_cycles got=%0d want=%0d", i, bcnt, W); end
            total++; if (q !== x_q[i]) begin bad++; $display("FAIL vec%0d_q got=%0d want=%0d", i, q, x_q[i]); end
            total++; if (q_sign !== x_qs[i]) begin bad++; $display("FAIL vec%0d_q_sign got=%0b want=%0b", i, q_sign, x_qs[i]); end
            total++; if (ovf !== 1'b0) begin bad++; $display("FAIL vec%0d_ovf got=%0b want=0", i, ovf); end
`ifdef MIX_DIV_REMAINDER_EN
            total++; if (r !== x_r[i] || r_sign !== t_as[i]) begin
                bad++; $display("FAIL vec%0d_rem got=%0d/%0b want=%0d/%0b", i, r, r_sign, x_r[i], t_as[i]);
            end
`else
            total++; if (r !== '0 || r_sign !== 1'b0) begin
                bad++; $display("FAIL vec%0d_rem got=%0d/%0b want=0/0 (x_r=%0d unused)", i, r, r_sign, x_r[i]);
            end
`endif
            model_div(t_hi[i], t_lo[i], t_as[i], t_v[i], 1'b0);
            @(negedge clk);
            total++; if (done !== 1'b0) begin bad++; $display("FAIL vec%0d_done_width got=%0b want=0", i, done); end
        end
    endtask

    task automatic test_overflow;
        logic [W-1:0] vs_tab[2] = '{30'd5, 30'd0};
        int lat, bcnt, extra;
        for (int i = 0; i < 2; i++) begin
            run_op(30'd5, 30'd1234, 1'b1, vs_tab[i], 1'b1, -1, -1, 1, lat, bcnt, extra);
            model_div(30'd5, 30'd1234, 1'b1, vs_tab[i], 1'b1);
            $display("overflow v=%0d: lat=%0d busy_cycles=%0d ovf=%0b q=%0d r=%0d", vs_tab[i], lat, bcnt, ovf, q, r);
            total++; if (lat !== 0) begin bad++; $display("FAIL ovf%0d_latency got=%0d want=0", i, lat); end
            total++; if (bcnt !== 0) begin bad++; $display("FAIL ovf%0d_busy got=%0d want=0", i, bcnt); end
            total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf%0d_flag got=%0b want=1", i, ovf); end
            total++; if ({q, q_sign, r, r_sign} !== {m_q, m_qs, m_r, m_rs}) begin
                bad++; $display("FAIL ovf%0d_hold got q=%0d qs=%0b r=%0d rs=%0b want q=%0d qs=%0b r=%0d rs=%0b",
                                i, q, q_sign, r, r_sign, m_q, m_qs, m_r, m_rs);
            end
            total++; if (extra !== 0) begin bad++; $display("FAIL ovf%0d_done_width got=%0d want=0", i, extra); end
        end
    endtask

    task automatic test_start_ignored;
        int lat, bcnt, extra;
        run_op(30'd1954, 30'd479399779, 1'b0, 30'd837504, 1'b0, 3, 10, W + 4, lat, bcnt, extra);
        model_div(30'd1954, 30'd479399779, 1'b0, 30'd837504, 1'b0);
        $display("start_ignored: lat=%0d extra_done=%0d q=%0d", lat, extra, q);
        total++; if (lat !== W) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, W); end
        total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_done got=%0d want=0", extra); end
        total++; if (q !== m_q) begin bad++; $display("FAIL ignore_q got=%0d want=%0d", q, m_q); end
    endtask

    task automatic test_reset_midrun;
        int lat, bcnt, extra, dn;
        dn = 0;
        @(negedge clk);
        a_hi = 30'd0; a_lo = 30'd100; a_sign = 1'b1; v = 30'd7; v_sign = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dn++;
            if (e == 11) reset = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset_midrun: busy=%0b done=%0b q=%0d r=%0d", busy, done, q, r);
        total++; if (busy !== 1'b0 || done !== 1'b0 || dn !== 0) begin
            bad++; $display("FAIL midrun_ctrl got busy=%0b done=%0b early_done=%0d want 0/0/0", busy, done, dn);
        end
        total++; if ({q, q_sign, r, r_sign, ovf} !== '0) begin
            bad++; $display("FAIL midrun_clear got q=%0d r=%0d ovf=%0b want 0", q, r, ovf);
        end
        m_q = '0; m_qs = 1'b0; m_r = '0; m_rs = 1'b0; m_ovf = 1'b0;
        run_op(30'd0, 30'd100, 1'b1, 30'd7, 1'b0, -1, -1, 0, lat, bcnt, extra);
        model_div(30'd0, 30'd100, 1'b1, 30'd7, 1'b0);
        $display("after_reset op: lat=%0d q=%0d r=%0d", lat, q, r);
        total++; if (lat !== W || q !== m_q || r !== m_r) begin
            bad++; $display("FAIL midrun_restart got lat=%0d q=%0d r=%0d want %0d/%0d/%0d", lat, q, r, W, m_q, m_r);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] hi, lo, vv;
        logic as_, vs;
        int lat, bcnt, extra;
        for (int i = 0; i < 30; i++) begin
            vv  = W'($urandom_range(0, 3) == 0 ? $urandom_range(1, 300) : $urandom_range(1, (1 << W) - 1));
            lo  = W'($urandom);
            as_ = 1'($urandom);
            vs  = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       hi = vv + W'($urandom_range(0, 3));
                1:       begin vv = '0; hi = W'($urandom_range(0, 9)); end
                2:       hi = '0;
                default: hi = W'($urandom % vv);
            endcase
            run_op(hi, lo, as_, vv, vs, -1, -1, 1, lat, bcnt, extra);
            model_div(hi, lo, as_, vv, vs);
            $display("rand %0d: hi=%0d lo=%0d v=%0d -> lat=%0d ovf=%0b q=%0d qs=%0b r=%0d rs=%0b",
                     i, hi, lo, vv, lat, ovf, q, q_sign, r, r_sign);
            total++; if (lat !== m_lat || bcnt !== m_lat || extra !== 0) begin
                bad++; $display("FAIL rand%0d_timing got lat=%0d busy=%0d extra=%0d want %0d/%0d/0", i, lat, bcnt, extra, m_lat, m_lat);
            end
            total++; if (ovf !== m_ovf) begin bad++; $display("FAIL rand%0d_ovf got=%0b want=%0b", i, ovf, m_ovf); end
            total++; if ({q, q_sign} !== {m_q, m_qs}) begin
                bad++; $display("FAIL rand%0d_q got=%0d/%0b want=%0d/%0b", i, q, q_sign, m_q, m_qs);
            end
            total++; if ({r, r_sign} !== {m_r, m_rs}) begin
                bad++; $display("FAIL rand%0d_r got=%0d/%0b want=%0d/%0b", i, r, r_sign, m_r, m_rs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_overflow();
        test_start_ignored();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
